// File: rtl/game_sequencer_pkg.sv
// Shared types for the falling-block sequencer: FSM states, move-vector bit
// positions, HID key codes and a saturating line-counter helper.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_SCAN  = 3'd4,
    ST_CLEAR = 3'd5,
    ST_OVER  = 3'd6
  } seq_state_t;

  // Bit positions shared by can_move, move_cmd and the key request vector.
  localparam int MV_L  = 0;
  localparam int MV_R  = 1;
  localparam int MV_D  = 2;
  localparam int MV_RL = 3;
  localparam int MV_RR = 4;
  localparam int MV_W  = 5;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_ROT_L = 8'h14;
  localparam logic [7:0] KEY_ROT_R = 8'h08;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the sequencer and the board / key / sync logic.
// master: the sequencer. slave: the board side that answers it.
interface game_sequencer_if;
  logic        frame_vs;
  logic [7:0]  keycode;
  logic [4:0]  can_move;
  logic        spawn_blocked;
  logic        row_full;
  logic        clear_ack;

  logic [4:0]  move_cmd;
  logic        get_new_block;
  logic        lock;
  logic [4:0]  scan_row;
  logic        clear_req;
  logic [15:0] lines;
  logic        game_over;

  modport master (
    input  frame_vs, keycode, can_move, spawn_blocked, row_full, clear_ack,
    output move_cmd, get_new_block, lock, scan_row, clear_req, lines, game_over
  );

  modport slave (
    output frame_vs, keycode, can_move, spawn_blocked, row_full, clear_ack,
    input  move_cmd, get_new_block, lock, scan_row, clear_req, lines, game_over
  );
endinterface

// File: rtl/game_sequencer_key_repeat.sv
// key_repeat: per-frame press-edge detection and held-key auto-repeat.
// Produces a one-hot key request, valid only in the cycle of a frame tick.
// A press edge is a keycode that differs from the one seen at the previous
// tick. Rotates fire on the press edge only; laterals fire on the press edge
// and then every REPEAT_FRAMES ticks while the same code stays held.
// GAME_SEQ_SOFT_DROP_EN: when defined, a held KEY_DOWN raises the D request
// on every tick so the sequencer can force gravity; otherwise D is never set.
module game_sequencer_key_repeat
  import game_sequencer_pkg::*;
#(
  parameter int REPEAT_FRAMES = 6
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            tick,
  input  logic [7:0]      keycode,
  output logic [MV_W-1:0] key_req
);

  localparam logic [3:0] REP_RELOAD = 4'(REPEAT_FRAMES - 1);

  logic [7:0] key_prev;
  logic [3:0] rep_cnt;
  logic       press;
  logic       rep_due;

  assign press   = (keycode != key_prev);
  assign rep_due = (rep_cnt == 4'd0);

  // Remember the code seen at each tick; down-count the repeat interval,
  // reloading on a new code or when the interval expires.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_prev <= 8'h00;
      rep_cnt  <= 4'd0;
    end else if (tick) begin
      key_prev <= keycode;
      if (press || rep_due) begin
        rep_cnt <= REP_RELOAD;
      end else begin
        rep_cnt <= rep_cnt - 4'd1;
      end
    end
  end

  // Decode the current code into a one-hot request for this tick.
  always_comb begin
    key_req = '0;
    if (tick) begin
      case (keycode)
        KEY_LEFT:  key_req[MV_L]  = press || rep_due;
        KEY_RIGHT: key_req[MV_R]  = press || rep_due;
        KEY_ROT_L: key_req[MV_RL] = press;
        KEY_ROT_R: key_req[MV_RR] = press;
`ifdef GAME_SEQ_SOFT_DROP_EN
        KEY_DOWN:  key_req[MV_D]  = 1'b1;
`endif
        default:   key_req = '0;
      endcase
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: frame-paced controller for the falling-block datapath.
// Owns gravity timing, key-to-move translation, piece spawn/lock, the row
// scan/clear handshake with the board, the line count and game-over.
// GAME_SEQ_SOFT_DROP_EN: when defined, holding KEY_DOWN forces gravity due
// on every frame tick (soft drop); the decode lives in the key_repeat block.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for the first frame tick
// ST_SPAWN | get_new_block pulse, then check spawn_blocked next cycle
// ST_FALL  | per-tick gravity and key moves
// ST_LOCK  | lock pulse, load scan_row with the top row
// ST_SCAN  | one row per cycle from top to 0 looking for full rows
// ST_CLEAR | clear_req held until clear_ack, then rescan same row
// ST_OVER  | game over, only Reset leaves
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int FALL_FRAMES   = 30,
  parameter int REPEAT_FRAMES = 6,
  parameter int ROWS          = 20
) (
  input  logic             Clk,
  input  logic             Reset,
  game_sequencer_if.master bus
);

  localparam logic [5:0] FALL_TC = 6'(FALL_FRAMES - 1);
  localparam logic [4:0] ROW_TOP = 5'(ROWS - 1);

  seq_state_t      state, state_nxt;
  logic            frame_vs_q;
  logic            tick;
  logic            fall_tick;
  logic [MV_W-1:0] key_req;
  logic            gravity_due;

  logic [5:0]      fall_cnt, fall_cnt_nxt;
  logic [4:0]      scan_row, scan_row_nxt;
  logic [15:0]     lines, lines_nxt;
  logic [MV_W-1:0] move_cmd, move_nxt;
  logic            get_new_block, gnb_nxt;
  logic            lock, lock_nxt;
  logic            clear_req, clear_req_nxt;
  logic            game_over, game_over_nxt;

  assign tick        = bus.frame_vs & ~frame_vs_q;
  assign fall_tick   = tick && (state == ST_FALL);
  assign gravity_due = (fall_cnt == FALL_TC) || key_req[MV_D];

  game_sequencer_key_repeat #(
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_key_repeat (
    .Clk     (Clk),
    .Reset   (Reset),
    .tick    (fall_tick),
    .keycode (bus.keycode),
    .key_req (key_req)
  );

  // State, counters and all registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      frame_vs_q    <= 1'b0;
      fall_cnt      <= 6'd0;
      scan_row      <= 5'd0;
      lines         <= 16'd0;
      move_cmd      <= '0;
      get_new_block <= 1'b0;
      lock          <= 1'b0;
      clear_req     <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_vs_q    <= bus.frame_vs;
      fall_cnt      <= fall_cnt_nxt;
      scan_row      <= scan_row_nxt;
      lines         <= lines_nxt;
      move_cmd      <= move_nxt;
      get_new_block <= gnb_nxt;
      lock          <= lock_nxt;
      clear_req     <= clear_req_nxt;
      game_over     <= game_over_nxt;
    end
  end

  // Next-state and next-output decisions; pulses default low every cycle.
  always_comb begin
    state_nxt     = state;
    fall_cnt_nxt  = fall_cnt;
    scan_row_nxt  = scan_row;
    lines_nxt     = lines;
    move_nxt      = '0;
    gnb_nxt       = 1'b0;
    lock_nxt      = 1'b0;
    clear_req_nxt = 1'b0;
    game_over_nxt = game_over;

    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nxt = ST_SPAWN;
          gnb_nxt   = 1'b1;
        end
      end

      ST_SPAWN: begin
        // The first SPAWN cycle carries the get_new_block pulse; the board
        // answers spawn_blocked for the new piece in the cycle after it.
        if (!get_new_block) begin
          if (bus.spawn_blocked) begin
            state_nxt     = ST_OVER;
            game_over_nxt = 1'b1;
          end else begin
            state_nxt    = ST_FALL;
            fall_cnt_nxt = 6'd0;
          end
        end
      end

      ST_FALL: begin
        if (tick) begin
          if (gravity_due) begin
            if (bus.can_move[MV_D]) begin
              move_nxt[MV_D] = 1'b1;
              fall_cnt_nxt   = 6'd0;
            end else begin
              state_nxt = ST_LOCK;
              lock_nxt  = 1'b1;
            end
          end else begin
            fall_cnt_nxt = fall_cnt + 6'd1;
            if (|key_req[MV_RR:MV_RL]) begin
              move_nxt[MV_RR:MV_RL] = key_req[MV_RR:MV_RL] & bus.can_move[MV_RR:MV_RL];
            end else begin
              move_nxt[MV_R:MV_L] = key_req[MV_R:MV_L] & bus.can_move[MV_R:MV_L];
            end
          end
        end
      end

      ST_LOCK: begin
        scan_row_nxt = ROW_TOP;
        state_nxt    = ST_SCAN;
      end

      ST_SCAN: begin
        if (bus.row_full) begin
          state_nxt     = ST_CLEAR;
          clear_req_nxt = 1'b1;
        end else if (scan_row == 5'd0) begin
          state_nxt = ST_SPAWN;
          gnb_nxt   = 1'b1;
        end else begin
          scan_row_nxt = scan_row - 5'd1;
        end
      end

      ST_CLEAR: begin
        // Rows above collapse into scan_row, so the same row is rescanned.
        if (clear_req && bus.clear_ack) begin
          state_nxt = ST_SCAN;
          lines_nxt = sat_inc16(lines);
        end else begin
          clear_req_nxt = 1'b1;
        end
      end

      ST_OVER: begin
        game_over_nxt = 1'b1;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.move_cmd      = move_cmd;
  assign bus.get_new_block = get_new_block;
  assign bus.lock          = lock;
  assign bus.scan_row      = scan_row;
  assign bus.clear_req     = clear_req;
  assign bus.lines         = lines;
  assign bus.game_over     = game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters
// (FALL_FRAMES=30, REPEAT_FRAMES=6, ROWS=20).
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   gnb_cnt = 0;
  int   lock_cnt = 0;

  game_sequencer_if bus();

  game_sequencer #(
    .FALL_FRAMES  (30),
    .REPEAT_FRAMES(6),
    .ROWS         (20)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.get_new_block) gnb_cnt++;
    if (bus.lock) lock_cnt++;
  endtask

  // One frame tick: frame_vs high for one cycle, then two quiet cycles.
  task automatic frame(output logic [4:0] mv, output int width);
    mv = '0;
    width = 0;
    bus.frame_vs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) bus.frame_vs = 1'b0;
      mv |= bus.move_cmd;
      if (bus.move_cmd != '0) width++;
    end
  endtask

  task automatic run_ticks(input int n, input int bitn, output logic [63:0] mask,
                           output int stray);
    logic [4:0] mv;
    int w;
    mask = '0;
    stray = 0;
    for (int t = 0; t < n; t++) begin
      frame(mv, w);
      if (mv[bitn]) mask[t] = 1'b1;
      if ((mv & ~(5'b00001 << bitn)) != 5'b0) stray++;
      if (w > 1) stray++;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.frame_vs = 1'b0;
    bus.keycode = 8'h00;
    bus.can_move = 5'h1F;
    bus.spawn_blocked = 1'b0;
    bus.row_full = 1'b0;
    bus.clear_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    gnb_cnt = 0;
    lock_cnt = 0;
  endtask

  task automatic restart();
    logic [4:0] mv;
    int w;
    reset_dut();
    frame(mv, w);
    gnb_cnt = 0;
    lock_cnt = 0;
  endtask

  initial begin
    logic [63:0] mask;
    logic [4:0]  mv;
    int stray, w, cyc, bad, exp_row, seen;
    logic [7:0] keys [8];
    keys = '{8'h04, 8'h14, 8'h07, 8'h08, 8'h16, 8'h04, 8'h00, 8'h14};

    // Reset values and first spawn
    reset_dut();
    check("rst_move", bus.move_cmd, 0);
    check("rst_gnb", bus.get_new_block, 0);
    check("rst_lock", bus.lock, 0);
    check("rst_clear_req", bus.clear_req, 0);
    check("rst_scan_row", bus.scan_row, 0);
    check("rst_lines", bus.lines, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_state", dut.state, ST_IDLE);
    frame(mv, w);
    check("spawn_gnb_count", gnb_cnt, 1);
    check("spawn_to_fall", dut.state, ST_FALL);

    // Gravity every 30 ticks
    run_ticks(60, MV_D, mask, stray);
    check("gravity_ticks", mask, 64'h0800_0000_2000_0000);
    check("gravity_stray", stray, 0);

    // Held left with auto-repeat
    restart();
    bus.keycode = KEY_LEFT;
    run_ticks(20, MV_L, mask, stray);
    check("left_repeat_ticks", mask, 64'h41041);
    check("left_repeat_stray", stray, 0);

    // Held left but illegal
    restart();
    bus.keycode = KEY_LEFT;
    bus.can_move = 5'h1E;
    run_ticks(20, MV_L, mask, stray);
    check("left_illegal_ticks", mask, 0);
    check("left_illegal_stray", stray, 0);

    // Held right, two repeats in 7 ticks
    restart();
    bus.keycode = KEY_RIGHT;
    run_ticks(7, MV_R, mask, stray);
    check("right_repeat_ticks", mask, 64'h41);
    check("right_repeat_stray", stray, 0);

    // Rotate fires once per press
    restart();
    bus.keycode = KEY_ROT_L;
    run_ticks(10, MV_RL, mask, stray);
    check("rot_l_ticks", mask, 64'h1);
    check("rot_l_stray", stray, 0);

    restart();
    bus.keycode = KEY_ROT_R;
    bus.can_move = 5'h0F;
    run_ticks(10, MV_RR, mask, stray);
    check("rot_r_illegal", mask | 64'(stray), 0);

    // Down key: soft drop only when the feature is built in
    restart();
    bus.keycode = KEY_DOWN;
    run_ticks(5, MV_D, mask, stray);
`ifdef GAME_SEQ_SOFT_DROP_EN
    check("down_key_ticks", mask, 64'h1F);
`else
    check("down_key_ticks", mask, 64'h0);
`endif
    check("down_key_stray", stray, 0);

    // Lock and full scan with no clears
    restart();
    bus.can_move = 5'h1B;
    run_ticks(29, MV_D, mask, stray);
    check("lock_pre_moves", mask | 64'(stray), 0);
    check("lock_pre_count", lock_cnt, 0);
    bus.frame_vs = 1'b1;
    step();
    bus.frame_vs = 1'b0;
    check("lock_pulse", bus.lock, 1);
    check("lock_state", dut.state, ST_LOCK);
    step();
    check("lock_width", bus.lock, 0);
    check("scan_top", bus.scan_row, 19);
    exp_row = 19;
    cyc = 1;
    bad = 0;
    seen = 0;
    while (seen == 0 && cyc < 40) begin
      step();
      cyc++;
      if (bus.get_new_block) seen = 1;
      else begin
        exp_row--;
        if (int'(bus.scan_row) != exp_row) bad++;
      end
    end
    check("scan_walk", bad, 0);
    check("lock_to_spawn_cycles", cyc, 21);
    check("lock_count", lock_cnt, 1);

    // Two full rows at the top, one delayed ack and one immediate ack
    restart();
    bus.can_move = 5'h1B;
    bus.row_full = 1'b1;
    run_ticks(29, MV_D, mask, stray);
    bus.frame_vs = 1'b1;
    step();
    bus.frame_vs = 1'b0;
    cyc = 0;
    while (!bus.clear_req && cyc < 10) begin
      step();
      cyc++;
    end
    check("clear_req_rise", bus.clear_req, 1);
    check("clear_row", bus.scan_row, 19);
    repeat (3) step();
    check("clear_req_held", bus.clear_req, 1);
    check("clear_lines_wait", bus.lines, 0);
    bus.clear_ack = 1'b1;
    step();
    check("clear1_drop", bus.clear_req, 0);
    check("clear1_lines", bus.lines, 1);
    step();
    check("clear2_req", bus.clear_req, 1);
    check("clear2_row", bus.scan_row, 19);
    check("ack_ignored_idle", bus.lines, 1);
    step();
    check("clear2_drop", bus.clear_req, 0);
    check("clear2_lines", bus.lines, 2);
    bus.clear_ack = 1'b0;
    bus.row_full = 1'b0;
    cyc = 0;
    while (!bus.get_new_block && cyc < 40) begin
      step();
      cyc++;
    end
    check("clear_then_spawn", bus.get_new_block, 1);
    bus.clear_ack = 1'b1;
    repeat (4) step();
    bus.clear_ack = 1'b0;
    check("stray_ack_lines", bus.lines, 2);
    check("stray_ack_req", bus.clear_req, 0);

    // Blocked spawn, sticky game over until reset
    reset_dut();
    bus.spawn_blocked = 1'b1;
    frame(mv, w);
    check("over_flag", bus.game_over, 1);
    check("over_state", dut.state, ST_OVER);
    gnb_cnt = 0;
    lock_cnt = 0;
    bad = 0;
    seen = 0;
    bus.row_full = 1'b1;
    bus.clear_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.keycode = keys[i];
      bus.can_move = (i % 2 == 0) ? 5'h1F : 5'h00;
      bus.spawn_blocked = (i % 3 == 0);
      frame(mv, w);
      if (bus.game_over !== 1'b1) bad++;
      if (mv != 5'b0 || bus.clear_req) seen++;
    end
    check("over_sticky", bad, 0);
    check("over_no_moves", seen, 0);
    check("over_no_pulses", gnb_cnt + lock_cnt, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("over_reset_flag", bus.game_over, 0);
    check("over_reset_state", dut.state, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
